// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM for the MIPS core (IF/ID/EXE/MEM/WB/HALT).
// Optional feature: define MULTICYCLE_ILLEGAL_TRAP_EN to trap unsupported instructions with fault.
module multicycle_control #(
  parameter logic [5:0]  HALT_OP     = 6'b111111,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [2:0] state,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic       mem_to_reg,
  output logic       mem_read,
  output logic       mem_write,
  output logic       alu_src_b,
  output logic       ext_sel,
  output logic [2:0] alu_op,
  output logic       instr_done,
  output logic       halted,
  output logic       fault
);

  localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EXE  = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    K_RT, K_ADDI, K_ORI, K_LW, K_SW, K_BEQ, K_J, K_JAL, K_HALT, K_ILL
  } kind_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             halted_q, halted_d;
  logic             fault_q, fault_d;

  kind_t            kind;
  logic [2:0]       rt_alu;
  logic [2:0]       dec_alu_op;
  logic             dec_src_b;
  logic             dec_ext;

  // Instruction class and the ALU setup it needs in EXE/WB
  always_comb begin
    kind   = K_ILL;
    rt_alu = ALU_ADD;
    if (op == HALT_OP) begin
      kind = K_HALT;
    end else begin
      case (op)
        6'b000000: begin
          kind = K_RT;
          case (func)
            6'b100000: rt_alu = ALU_ADD;
            6'b100010: rt_alu = ALU_SUB;
            6'b100100: rt_alu = ALU_AND;
            6'b100101: rt_alu = ALU_OR;
            6'b101010: rt_alu = ALU_SLT;
            6'b000000: rt_alu = ALU_SLL;
            default:   kind   = K_ILL;
          endcase
        end
        6'b001000: kind = K_ADDI;
        6'b001101: kind = K_ORI;
        6'b100011: kind = K_LW;
        6'b101011: kind = K_SW;
        6'b000100: kind = K_BEQ;
        6'b000010: kind = K_J;
        6'b000011: kind = K_JAL;
        default:   kind = K_ILL;
      endcase
    end

    dec_alu_op = ALU_ADD;
    dec_src_b  = 1'b0;
    dec_ext    = 1'b0;
    case (kind)
      K_RT:        dec_alu_op = rt_alu;
      K_ADDI:      begin dec_src_b = 1'b1; dec_ext = 1'b1; end
      K_ORI:       begin dec_alu_op = ALU_OR; dec_src_b = 1'b1; end
      K_LW, K_SW:  begin dec_src_b = 1'b1; dec_ext = 1'b1; end
      K_BEQ:       dec_alu_op = ALU_SUB;
      default:     dec_alu_op = ALU_ADD;
    endcase
  end

  // Next-state and per-cycle control decode
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    halted_d   = halted_q;
    fault_d    = fault_q;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 2'b00;
    mem_to_reg = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_src_b  = 1'b0;
    ext_sel    = 1'b0;
    alu_op     = ALU_ADD;
    instr_done = 1'b0;

    case (state_q)
      S_IF: begin
        ir_write = 1'b1;
        pc_write = 1'b1;
        state_d  = S_ID;
      end
      S_ID: begin
        case (kind)
          K_J: begin
            pc_write   = 1'b1;
            pc_src     = 2'b11;
            instr_done = 1'b1;
            state_d    = S_IF;
          end
          K_JAL: begin
            pc_write   = 1'b1;
            pc_src     = 2'b11;
            reg_write  = 1'b1;
            reg_dst    = 2'b10;
            instr_done = 1'b1;
            state_d    = S_IF;
          end
          K_HALT: begin
            instr_done = 1'b1;
            state_d    = S_HALT;
          end
          K_ILL: begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
            fault_d    = 1'b1;
            state_d    = S_HALT;
`else
            instr_done = 1'b1;
            state_d    = S_IF;
`endif
          end
          default: state_d = S_EXE;
        endcase
      end
      S_EXE: begin
        alu_op    = dec_alu_op;
        alu_src_b = dec_src_b;
        ext_sel   = dec_ext;
        if (kind == K_BEQ) begin
          pc_write   = zero;
          pc_src     = 2'b01;
          instr_done = 1'b1;
          state_d    = S_IF;
        end else if (kind == K_LW || kind == K_SW) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_read  = (kind == K_LW);
        mem_write = (kind == K_SW);
        if (mem_ready) begin
          cnt_d = '0;
          if (kind == K_LW) begin
            state_d = S_WB;
          end else begin
            instr_done = 1'b1;
            state_d    = S_IF;
          end
        end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
          cnt_d   = '0;
          fault_d = 1'b1;
          state_d = S_HALT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (kind == K_RT) ? 2'b01 : 2'b00;
        mem_to_reg = (kind == K_LW);
        alu_op     = dec_alu_op;
        alu_src_b  = dec_src_b;
        ext_sel    = dec_ext;
        instr_done = 1'b1;
        state_d    = S_IF;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IF;
    endcase

    if (state_d == S_HALT) begin
      halted_d = 1'b1;
    end

    // Nothing may strobe while reset is being applied
    if (reset) begin
      pc_write   = 1'b0;
      pc_src     = 2'b00;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 2'b00;
      mem_to_reg = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      alu_src_b  = 1'b0;
      ext_sel    = 1'b0;
      alu_op     = ALU_ADD;
      instr_done = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IF;
      cnt_q    <= '0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
    end
  end

  assign state  = state_q;
  assign halted = halted_q;
  assign fault  = fault_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench for multicycle_control: per-instruction expected
// cycle sequences are built from the instruction-level rules and compared each cycle.
module tb_multicycle_control;

  localparam int unsigned TO = 16;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_HALT = 6'b111111;

  typedef struct packed {
    logic [2:0] st;
    logic       pcw;
    logic [1:0] pcs;
    logic       irw;
    logic       rw;
    logic [1:0] rd;
    logic       m2r;
    logic       mr;
    logic       mw;
    logic       asb;
    logic       ext;
    logic [2:0] aop;
    logic       done;
    logic       hlt;
    logic       flt;
  } vec_t;

  typedef struct {
    vec_t v;
    logic rdy;
  } step_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, func;
  logic       zero, mem_ready;
  logic [2:0] state;
  logic       pc_write, ir_write, reg_write, mem_to_reg, mem_read, mem_write;
  logic       alu_src_b, ext_sel, instr_done, halted, fault;
  logic [1:0] pc_src, reg_dst;
  logic [2:0] alu_op;

  int checks   = 0;
  int failures = 0;
  step_t steps[$];
  vec_t  obs;

  multicycle_control #(.HALT_OP(OP_HALT), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .op(op), .func(func), .zero(zero), .mem_ready(mem_ready),
    .state(state), .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .mem_read(mem_read), .mem_write(mem_write), .alu_src_b(alu_src_b),
    .ext_sel(ext_sel), .alu_op(alu_op), .instr_done(instr_done),
    .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  assign obs = {state, pc_write, pc_src, ir_write, reg_write, reg_dst, mem_to_reg,
                mem_read, mem_write, alu_src_b, ext_sel, alu_op, instr_done, halted, fault};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (op=%b func=%b t=%0t)", tag, got, exp, op, func, $time);
    end
  endtask

  function automatic bit r_func_ok(input logic [5:0] f, output logic [2:0] a);
    r_func_ok = 1'b1;
    a = 3'b000;
    case (f)
      6'b100000: a = 3'b000;
      6'b100010: a = 3'b001;
      6'b100100: a = 3'b010;
      6'b100101: a = 3'b011;
      6'b101010: a = 3'b100;
      6'b000000: a = 3'b101;
      default:   r_func_ok = 1'b0;
    endcase
  endfunction

  function automatic bit legal(input logic [5:0] o, input logic [5:0] f);
    logic [2:0] a;
    case (o)
      OP_R: legal = r_func_ok(f, a);
      OP_ADDI, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  endfunction

  // ALU setting an instruction uses for its computation (EXE, repeated in WB)
  task automatic alu_of(input logic [5:0] o, input logic [5:0] f, inout vec_t v);
    logic [2:0] a;
    case (o)
      OP_R:          begin void'(r_func_ok(f, a)); v.aop = a; end
      OP_ADDI:       begin v.aop = 3'b000; v.asb = 1'b1; v.ext = 1'b1; end
      OP_ORI:        begin v.aop = 3'b011; v.asb = 1'b1; end
      OP_LW, OP_SW:  begin v.aop = 3'b000; v.asb = 1'b1; v.ext = 1'b1; end
      OP_BEQ:        v.aop = 3'b001;
      default:       v.aop = 3'b000;
    endcase
  endtask

  task automatic push(input vec_t v, input logic rdy);
    step_t s;
    s.v = v;
    s.rdy = rdy;
    steps.push_back(s);
  endtask

  task automatic push_halt(input logic f, input int n);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v = '0; v.st = 3'd5; v.hlt = 1'b1; v.flt = f;
      push(v, 1'($urandom));
    end
  endtask

  // Expected cycle-by-cycle behaviour of one instruction; lat = cycles before mem_ready
  task automatic push_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                            input int lat, output bit ends_halt);
    vec_t v;
    int nw;
    ends_halt = 1'b0;
    v = '0; v.irw = 1'b1; v.pcw = 1'b1;
    push(v, 1'($urandom));
    v = '0; v.st = 3'd1;
    if (o == OP_HALT) begin
      v.done = 1'b1; push(v, 1'($urandom)); push_halt(1'b0, 10); ends_halt = 1'b1; return;
    end
    if (!legal(o, f)) begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      push(v, 1'($urandom)); push_halt(1'b1, 4); ends_halt = 1'b1;
`else
      v.done = 1'b1; push(v, 1'($urandom));
`endif
      return;
    end
    if (o == OP_J || o == OP_JAL) begin
      v.pcw = 1'b1; v.pcs = 2'b11; v.done = 1'b1;
      if (o == OP_JAL) begin v.rw = 1'b1; v.rd = 2'b10; end
      push(v, 1'($urandom)); return;
    end
    push(v, 1'($urandom));
    v = '0; v.st = 3'd2; alu_of(o, f, v);
    if (o == OP_BEQ) begin
      v.pcw = z; v.pcs = 2'b01; v.done = 1'b1; push(v, 1'($urandom)); return;
    end
    push(v, 1'($urandom));
    if (o == OP_LW || o == OP_SW) begin
      nw = (lat < int'(TO)) ? lat : int'(TO);
      v = '0; v.st = 3'd3; v.mr = (o == OP_LW); v.mw = (o == OP_SW);
      for (int i = 0; i < nw; i++) push(v, 1'b0);
      if (lat >= int'(TO)) begin push_halt(1'b1, 4); ends_halt = 1'b1; return; end
      v.done = (o == OP_SW);
      push(v, 1'b1);
      if (o == OP_SW) return;
    end
    v = '0; v.st = 3'd4; alu_of(o, f, v);
    v.rw = 1'b1; v.rd = (o == OP_R) ? 2'b01 : 2'b00; v.m2r = (o == OP_LW); v.done = 1'b1;
    push(v, 1'($urandom));
  endtask

  task automatic run_steps(input string tag);
    step_t s;
    int k = 0;
    while (steps.size() > 0) begin
      s = steps.pop_front();
      mem_ready = s.rdy;
      @(negedge clk);
      check($sformatf("%s[%0d]", tag, k), 32'(obs), 32'(s.v));
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  task automatic exec(input string tag, input logic [5:0] o, input logic [5:0] f,
                      input logic z, input int lat, output bit ends_halt);
    op = o; func = f; zero = z;
    push_instr(o, f, z, lat, ends_halt);
    run_steps(tag);
  endtask

  task automatic do_reset();
    vec_t m;
    m = '1; m.st = '0; m.hlt = 1'b0; m.flt = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("rst_strobes", 32'(obs & m), 32'd0);
    @(posedge clk);
    #1;
    check("rst_flags", {29'd0, state}, 32'd0);
    check("rst_sticky", {30'd0, halted, fault}, 32'd0);
    reset = 1'b0;
  endtask

  initial begin
    bit h;
    logic [5:0] o, f;
    int sel, lat;
    reset = 1'b1; op = '0; func = '0; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    exec("add",    OP_R,   6'b100000, 1'b0, 0, h);
    exec("lw3",    OP_LW,  6'b010101, 1'b0, 3, h);
    exec("beq_z1", OP_BEQ, 6'b000000, 1'b1, 0, h);
    exec("beq_z0", OP_BEQ, 6'b000000, 1'b0, 0, h);
    exec("jal",    OP_JAL, 6'b111000, 1'b0, 0, h);
    exec("j",      OP_J,   6'b000000, 1'b1, 0, h);
    exec("addi",   OP_ADDI,6'b000001, 1'b0, 0, h);
    exec("ori",    OP_ORI, 6'b000001, 1'b0, 0, h);
    exec("sw0",    OP_SW,  6'b000000, 1'b0, 0, h);
    exec("sub",    OP_R,   6'b100010, 1'b0, 0, h);
    exec("and",    OP_R,   6'b100100, 1'b0, 0, h);
    exec("or",     OP_R,   6'b100101, 1'b0, 0, h);
    exec("slt",    OP_R,   6'b101010, 1'b0, 0, h);
    exec("sll",    OP_R,   6'b000000, 1'b0, 0, h);
    exec("lw15",   OP_LW,  6'b000000, 1'b0, int'(TO) - 1, h);
    exec("sw_to",  OP_SW,  6'b000000, 1'b0, int'(TO), h);
    do_reset();
    exec("halt",   OP_HALT,6'b000000, 1'b0, 0, h);
    do_reset();
    exec("ill_op", 6'b010101, 6'b000000, 1'b0, 0, h);
    if (h) do_reset();
    exec("ill_fn", OP_R,   6'b111111, 1'b0, 0, h);
    if (h) do_reset();

    // Reset while stalled in MEM
    op = OP_LW; func = '0; zero = 1'b0;
    push_instr(OP_LW, 6'd0, 1'b0, int'(TO), h);
    while (steps.size() > 5) void'(steps.pop_back());
    run_steps("lw_rst");
    do_reset();
    exec("post_rst", OP_R, 6'b100000, 1'b0, 0, h);

    for (int n = 0; n < 200; n++) begin
      sel = int'($urandom_range(0, 99));
      f = 6'($urandom);
      lat = int'($urandom_range(0, 4));
      if (sel < 30) begin
        o = OP_R;
        case ($urandom_range(0, 5))
          0: f = 6'b100000; 1: f = 6'b100010; 2: f = 6'b100100;
          3: f = 6'b100101; 4: f = 6'b101010; default: f = 6'b000000;
        endcase
      end else if (sel < 40) o = OP_ADDI;
      else if (sel < 48) o = OP_ORI;
      else if (sel < 62) o = OP_LW;
      else if (sel < 74) o = OP_SW;
      else if (sel < 84) o = OP_BEQ;
      else if (sel < 88) o = OP_J;
      else if (sel < 92) o = OP_JAL;
      else if (sel < 94) o = OP_HALT;
      else if (sel < 96) begin
        o = OP_LW; lat = int'(TO);
      end else begin
        o = 6'($urandom);
        while (legal(o, f) || o == OP_HALT) begin
          o = 6'($urandom);
          f = 6'($urandom);
        end
      end
      exec($sformatf("rnd%0d", n), o, f, 1'($urandom), lat, h);
      if (h) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
